riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit directly downstream of riscv_alu. Consumes the ALU result (alu_p_o) as the effective address plus the one-hot load/store decode flags. It drives a single-outstanding request/grant/rvalid data-memory port and returns sign- or zero-extended load data for writeback. One memory op is in flight at a time, with a ready/valid handshake on the issue side.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_gnt_i or mem_rvalid_i before bus error (used only with LSU_TIMEOUT_EN)
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_i  in  1  issue valid
ready_o  out  1  LSU can accept; high only in IDLE
is_lb, is_lh, is_lw, is_lbu, is_lhu  in  1 each  load decode flags, one-hot
is_sb, is_sh, is_sw  in  1 each  store decode flags, one-hot
alu_p_i  in  32  effective address (ALU output)
rs2_data_i  in  32  store data
rd_idx_i  in  5  load destination register
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store
mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wstrb_o  out  4  byte-lane write strobes
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data
wb_valid_o  out  1  one-cycle pulse: load result valid
wb_rd_o  out  5  destination register
wb_data_o  out  32  extended load data
st_done_o  out  1  one-cycle pulse: store granted
misalign_o  out  1  one-cycle pulse: misaligned access, no memory request issued
bus_err_o  out  1  one-cycle pulse: timeout (LSU_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except ready_o=1. Internal address, data and rd registers cleared.
- Accept: valid_i & ready_o & (any of the 8 flags). Latch flags, alu_p_i, rs2_data_i, rd_idx_i. valid_i with no flag set is ignored and the unit stays in IDLE.
- Flags not one-hot is undefined input; verification excludes it.
- FSM: IDLE -> REQ (aligned op) or ERR (misaligned); REQ -> WAIT_RD (load & gnt) or DONE (store & gnt); WAIT_RD -> DONE on mem_rvalid_i; DONE -> IDLE; ERR -> IDLE.
- Misalignment rules: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. Misaligned ops go to ERR, pulse misalign_o for 1 cycle, and issue no mem_req_o.
- REQ: mem_req_o=1, with mem_we_o/addr/wstrb/wdata stable, until the cycle mem_gnt_i=1 is sampled high. mem_req_o is 0 in all other states.
- Store lanes:
  - sb: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, wstrb=addr[1]?1100:0011.
  - sw: wdata=rs2, wstrb=1111.
  - Loads: wstrb=0000, we=0.
- Load data is captured on mem_rvalid_i. Extraction: shift rdata right by 8*addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- DONE: wb_valid_o=1 with wb_rd_o/wb_data_o (loads) or st_done_o=1 (stores), for exactly 1 cycle. wb_data_o holds its value until the next load completes.
- Latency (accept at edge T, gnt and rvalid at earliest):
  - Store: mem_req_o high in cycle T+1, st_done_o in T+2.
  - Load: mem_req_o high in T+1, rvalid sampled in T+2, wb_valid_o in T+3.
  - ready_o returns to 1 the cycle after DONE/ERR.
- mem_rvalid_i outside WAIT_RD is ignored, including a stale response after a mid-operation reset.
- mem_gnt_i and mem_rvalid_i in the same REQ cycle: only gnt is honoured. The memory must return rvalid no earlier than the cycle after gnt.
- Reset mid-operation aborts immediately. No pulse outputs fire for the aborted op.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a CNT_W counter clears on entry to REQ/WAIT_RD and increments each cycle without gnt/rvalid. On reaching TIMEOUT_CYCLES the FSM goes to ERR: mem_req_o drops, bus_err_o pulses 1 cycle, and there is no wb_valid_o or st_done_o.
- Undefined: no counter; the unit waits indefinitely and bus_err_o is constant 0.

Test Plan:
- lw addr 0x100, rdata 0xDEADBEEF (gnt T+1, rvalid T+2) -> mem_addr_o=0x100, wb_valid_o at T+3, wb_data_o=0xDEADBEEF, wb_rd_o=rd_idx_i.
- lb addr 0x103, rdata 0x80112233 -> wb_data_o=0xFFFFFF80; same with lbu -> 0x00000080; lhu addr 0x102 -> 0x00008011.
- sh addr 0x206, rs2 0x0000ABCD -> mem_wstrb_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1, st_done_o one cycle after gnt.
- sw addr 0x301 -> misalign_o pulse, mem_req_o never asserted, ready_o=1 two cycles after accept.
- lw with gnt delayed 3 cycles: mem_req_o and address held stable 4 cycles; rst asserted during WAIT_RD -> ready_o=1 immediately, and a late rvalid produces no wb_valid_o.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with no rvalid -> bus_err_o pulses after 4 wait cycles, no wb_valid_o, back to IDLE.

Source files
------------

// File: rtl/riscv_lsu.sv
`timescale 1ns/1ps
// riscv_lsu -- load/store unit sitting behind riscv_alu.
//
// Takes the ALU result as the effective address and a one-hot load/store
// decode. It runs one memory operation at a time over a req/gnt/rvalid data
// port and returns sign/zero-extended load data for writeback.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   -> a CNT_W-bit wait counter aborts a REQ/WAIT_RD that has
//                waited TIMEOUT_CYCLES cycles; bus_err_o pulses for one cycle
//   undefined -> the unit waits indefinitely, bus_err_o is tied 0
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   valid_i        issue valid          ready_o     high only when idle
//   is_lb..is_lhu  one-hot load decode  is_sb..is_sw one-hot store decode
//   alu_p_i        effective address    rs2_data_i  store data
//   rd_idx_i       load destination register
//   mem_req_o/mem_we_o/mem_addr_o/mem_wstrb_o/mem_wdata_o  request side
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i                     response side
//   wb_valid_o/wb_rd_o/wb_data_o  load writeback (wb_valid_o is a pulse)
//   st_done_o      store granted pulse
//   misalign_o     misaligned access pulse (no memory request issued)
//   bus_err_o      timeout pulse
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_lb,
  input  logic        is_lh,
  input  logic        is_lw,
  input  logic        is_lbu,
  input  logic        is_lhu,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  input  logic [31:0] alu_p_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_idx_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        st_done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 1 || (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_cfg
    $error("riscv_lsu: CNT_W cannot hold TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_RD, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
  } op_t;

  state_t      state, state_nxt;
  op_t         op_in, op_p1;
  logic [31:0] addr_p1, rs2_p1, ld_data_p2;
  logic [4:0]  rd_p1;
  logic        accept, misalign_in, is_load_p1, is_store_p1;
  logic        timeout_hit, err_is_bus;

  function automatic logic [3:0] store_strb(input op_t op, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    if (op.sb)      s = 4'b0001 << off;
    else if (op.sh) s = off[1] ? 4'b1100 : 4'b0011;
    else if (op.sw) s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] store_data(input op_t op, input logic [31:0] d);
    logic [31:0] w;
    w = 32'd0;
    if (op.sb)      w = {4{d[7:0]}};
    else if (op.sh) w = {2{d[15:0]}};
    else if (op.sw) w = d;
    return w;
  endfunction

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extract(input op_t op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic        [31:0] shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    shifted = rdata >> {off, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    r = shifted;
    if (op.lb)       r = 32'(b);
    else if (op.lbu) r = 32'(shifted[7:0]);
    else if (op.lh)  r = 32'(h);
    else if (op.lhu) r = 32'(shifted[15:0]);
    return r;
  endfunction

  assign op_in       = {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw};
  assign accept      = valid_i && (state == S_IDLE) && (|op_in);
  assign misalign_in = ((op_in.lh | op_in.lhu | op_in.sh) & alu_p_i[0]) |
                       ((op_in.lw | op_in.sw) & (alu_p_i[1:0] != 2'b00));
  assign is_load_p1  = op_p1.lb | op_p1.lh | op_p1.lw | op_p1.lbu | op_p1.lhu;
  assign is_store_p1 = op_p1.sb | op_p1.sh | op_p1.sw;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  // A cycle with gnt/rvalid (or any cycle outside REQ/WAIT_RD) restarts the
  // count, so it is zero on entry to either waiting state.
  assign waiting     = ((state == S_REQ) && !mem_gnt_i) ||
                       ((state == S_WAIT_RD) && !mem_rvalid_i);
  assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      err_is_bus <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE)  err_is_bus <= 1'b0;
      else if (timeout_hit) err_is_bus <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_is_bus  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = misalign_in ? S_ERR : S_REQ;
      // gnt wins over a same-cycle rvalid: rvalid only counts in WAIT_RD.
      S_REQ:     if (mem_gnt_i)        state_nxt = is_load_p1 ? S_WAIT_RD : S_DONE;
                 else if (timeout_hit) state_nxt = S_ERR;
      S_WAIT_RD: if (mem_rvalid_i)     state_nxt = S_DONE;
                 else if (timeout_hit) state_nxt = S_ERR;
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: operation latched at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p1   <= '0;
      addr_p1 <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else if (accept) begin
      op_p1   <= op_in;
      addr_p1 <= alu_p_i;
      rs2_p1  <= rs2_data_i;
      rd_p1   <= rd_idx_i;
    end
  end

  // Stage p2: load data captured on rvalid, held until the next load returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  ld_data_p2 <= '0;
    else if (state == S_WAIT_RD && mem_rvalid_i) ld_data_p2 <= load_extract(op_p1, addr_p1[1:0], mem_rdata_i);
  end

  assign ready_o     = (state == S_IDLE);
  assign mem_req_o   = (state == S_REQ);
  assign mem_we_o    = mem_req_o & is_store_p1;
  assign mem_addr_o  = mem_req_o ? {addr_p1[31:2], 2'b00} : 32'd0;
  assign mem_wstrb_o = mem_req_o ? store_strb(op_p1, addr_p1[1:0]) : 4'd0;
  assign mem_wdata_o = mem_req_o ? store_data(op_p1, rs2_p1) : 32'd0;

  assign wb_valid_o  = (state == S_DONE) & is_load_p1;
  assign st_done_o   = (state == S_DONE) & is_store_p1;
  assign wb_rd_o     = rd_p1;
  assign wb_data_o   = ld_data_p2;
  assign misalign_o  = (state == S_ERR) & ~err_is_bus;
  assign bus_err_o   = (state == S_ERR) & err_is_bus;

endmodule

// File: tb/tb_riscv_lsu.sv
`timescale 1ns/1ps
// Self-checking bench for riscv_lsu: reset, ignored issue, directed
// loads/stores/misalignment, delayed grant, reset abort, randomized traffic.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o;
  logic        is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
  logic [31:0] alu_p_i, rs2_data_i;
  logic [4:0]  rd_idx_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        st_done_o, misalign_o, bus_err_o;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .is_lb(is_lb), .is_lh(is_lh), .is_lw(is_lw), .is_lbu(is_lbu), .is_lhu(is_lhu),
    .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
    .alu_p_i(alu_p_i), .rs2_data_i(rs2_data_i), .rd_idx_i(rd_idx_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .st_done_o(st_done_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_load = 32'd0;

  // Observations from the most recent do_op.
  int          o_req_n, o_wb_n, o_st_n, o_mis_n, o_err_n, o_done_k, o_rdy_k;
  logic        o_rdy_before, o_we, o_unstable;
  logic [31:0] o_addr, o_wdata, o_wb_data;
  logic [3:0]  o_wstrb;
  logic [4:0]  o_wb_rd;

  // ---------------- reference model ----------------
  // op codes: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw
  function automatic int op_size(input int op);
    if (op == 0 || op == 3 || op == 5) return 1;
    if (op == 1 || op == 4 || op == 6) return 2;
    return 4;
  endfunction

  function automatic bit op_load(input int op);
    return op < 5;
  endfunction

  function automatic bit op_mis(input int op, input logic [31:0] a);
    return (int'(a[1:0]) % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input int op, input logic [31:0] a);
    int m;
    if (op_load(op)) return 4'd0;
    m = ((1 << op_size(op)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
    if (op_size(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (op_size(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * a[1:0]);
    if (op_size(op) == 1) begin
      v = v & 32'hFF;
      if (op == 0 && v >= 32'd128) v = v - 32'd256;
    end else if (op_size(op) == 2) begin
      v = v & 32'hFFFF;
      if (op == 1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Control summary: req cycles, first pulse cycle, ready cycle, wb/st/mis/err counts, ready at issue.
  function automatic logic [63:0] m_ctl(input int op, input logic [31:0] a, input int gd, input int rvd);
    if (op_mis(op, a)) return {8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
    if (!op_load(op))  return {8'(1 + gd), 8'(2 + gd), 8'(3 + gd), 8'd0, 8'd1, 8'd0, 8'd0, 8'd1};
    return {8'(1 + gd), 8'(3 + gd + rvd), 8'(4 + gd + rvd), 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  endfunction

  function automatic logic [63:0] obs_ctl();
    return {8'(o_req_n), 8'(o_done_k), 8'(o_rdy_k), 8'(o_wb_n), 8'(o_st_n),
            8'(o_mis_n), 8'(o_err_n), 7'd0, o_rdy_before};
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic set_flags(input int op);
    logic [7:0] f;
    f = (op >= 0 && op < 8) ? (8'h80 >> op) : 8'h00;
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = f;
  endtask

  // Issue one op (called near a negedge with the unit idle) and record what
  // the DUT does until ready_o returns. gd = cycles of req before gnt,
  // rvd = extra cycles between gnt and rvalid, noise = spurious rvalid in REQ.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [31:0] rdata,
                       input int gd, input int rvd, input bit noise);
    bit ld;
    ld = op_load(op);
    o_req_n = 0; o_wb_n = 0; o_st_n = 0; o_mis_n = 0; o_err_n = 0;
    o_done_k = 0; o_rdy_k = 0; o_unstable = 1'b0;
    o_addr = '0; o_we = 1'b0; o_wstrb = '0; o_wdata = '0; o_wb_data = '0; o_wb_rd = '0;
    o_rdy_before = ready_o;
    valid_i = 1'b1; set_flags(op); alu_p_i = addr; rs2_data_i = rs2; rd_idx_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0; set_flags(-1);
    alu_p_i = $urandom; rs2_data_i = $urandom; rd_idx_i = 5'($urandom_range(0, 31));
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      mem_gnt_i    = (k == 1 + gd);
      mem_rvalid_i = (ld && k == 2 + gd + rvd) || (noise && k <= 1 + gd);
      mem_rdata_i  = (ld && k == 2 + gd + rvd) ? rdata : $urandom;
      @(negedge clk);
      if (mem_req_o) begin
        if (o_req_n == 0) begin
          o_addr = mem_addr_o; o_we = mem_we_o; o_wstrb = mem_wstrb_o; o_wdata = mem_wdata_o;
        end else if ({mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o} !== {o_addr, o_we, o_wstrb, o_wdata}) begin
          o_unstable = 1'b1;
        end
        o_req_n++;
      end
      if (wb_valid_o) begin o_wb_n++; o_wb_data = wb_data_o; o_wb_rd = wb_rd_o; end
      if (st_done_o)  o_st_n++;
      if (misalign_o) o_mis_n++;
      if (bus_err_o)  o_err_n++;
      if (o_done_k == 0 && (wb_valid_o || st_done_o || misalign_o || bus_err_o)) o_done_k = k;
      if (ready_o) begin o_rdy_k = k; break; end
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b1; set_flags(2); alu_p_i = 32'h100; rs2_data_i = 32'h1234; rd_idx_i = 5'd3;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o, wb_valid_o,
         wb_rd_o, wb_data_o, st_done_o, misalign_o, bus_err_o} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs got ready=%b req=%b addr=%h wb_valid=%b wb_rd=%0d wb_data=%h st=%b mis=%b err=%b want ready=1 rest 0",
               ready_o, mem_req_o, mem_addr_o, wb_valid_o, wb_rd_o, wb_data_o, st_done_o, misalign_o, bus_err_o);
    end
    valid_i = 1'b0; set_flags(-1); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ready_o, mem_req_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release got ready=%b req=%b want ready=1 req=0", ready_o, mem_req_o);
    end
  endtask

  task automatic test_no_flag();
    int bad_cycles;
    bad_cycles = 0;
    valid_i = 1'b1; set_flags(-1); alu_p_i = 32'h0000_0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({ready_o, mem_req_o, wb_valid_o, st_done_o, misalign_o, bus_err_o} !== 6'b100000) bad_cycles++;
    end
    valid_i = 1'b0;
    n_vec++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL no_flag_ignored got %0d non-idle cycles want 0", bad_cycles);
    end
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr, rs2, rdata;
    logic [4:0]  rd;
    int          gd, rvd;
    bit          noise;
    logic [63:0] ctl;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wdata, wb;
  } dir_t;

  task automatic test_directed();
    dir_t t[8];
    t[0] = '{2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5'd5,  0, 0, 1'b0, 64'h01_03_04_01_00_00_00_01, 32'h100, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    t[1] = '{0, 32'h0000_0103, 32'h0,        32'h8011_2233, 5'd9,  0, 0, 1'b0, 64'h01_03_04_01_00_00_00_01, 32'h100, 4'b0000, 32'h0,         32'hFFFF_FF80};
    t[2] = '{3, 32'h0000_0103, 32'h0,        32'h8011_2233, 5'd10, 0, 0, 1'b0, 64'h01_03_04_01_00_00_00_01, 32'h100, 4'b0000, 32'h0,         32'h0000_0080};
    t[3] = '{4, 32'h0000_0102, 32'h0,        32'h8011_2233, 5'd11, 0, 0, 1'b0, 64'h01_03_04_01_00_00_00_01, 32'h100, 4'b0000, 32'h0,         32'h0000_8011};
    t[4] = '{6, 32'h0000_0206, 32'h0000_ABCD, 32'h0,        5'd0,  0, 0, 1'b0, 64'h01_02_03_00_01_00_00_01, 32'h204, 4'b1100, 32'hABCD_ABCD, 32'h0};
    t[5] = '{7, 32'h0000_0301, 32'h1111_2222, 32'h0,        5'd0,  0, 0, 1'b0, 64'h00_01_02_00_00_01_00_01, 32'h0,   4'b0000, 32'h0,         32'h0};
    t[6] = '{2, 32'h0000_0480, 32'h0,        32'h1234_5678, 5'd3,  3, 0, 1'b0, 64'h04_06_07_01_00_00_00_01, 32'h480, 4'b0000, 32'h0,         32'h1234_5678};
    t[7] = '{5, 32'h0000_0013, 32'hCAFE_005A, 32'h0,        5'd0,  2, 0, 1'b1, 64'h03_04_05_00_01_00_00_01, 32'h010, 4'b1000, 32'h5A5A_5A5A, 32'h0};
    for (int i = 0; i < 8; i++) begin
      do_op(t[i].op, t[i].addr, t[i].rs2, t[i].rd, t[i].rdata, t[i].gd, t[i].rvd, t[i].noise);
      n_vec++;
      if (obs_ctl() !== t[i].ctl) begin
        n_bad++;
        $display("FAIL dir%0d_ctl got %h want %h", i, obs_ctl(), t[i].ctl);
      end
      if (!op_mis(t[i].op, t[i].addr)) begin
        n_vec++;
        if ({o_addr, o_we, o_wstrb, o_unstable} !== {t[i].maddr, !op_load(t[i].op), t[i].strb, 1'b0}) begin
          n_bad++;
          $display("FAIL dir%0d_req got addr=%h we=%b strb=%b unstable=%b want addr=%h we=%b strb=%b unstable=0",
                   i, o_addr, o_we, o_wstrb, o_unstable, t[i].maddr, !op_load(t[i].op), t[i].strb);
        end
      end
      if (op_load(t[i].op)) begin
        n_vec++;
        if ({o_wb_data, o_wb_rd} !== {t[i].wb, t[i].rd}) begin
          n_bad++;
          $display("FAIL dir%0d_wb got data=%h rd=%0d want data=%h rd=%0d", i, o_wb_data, o_wb_rd, t[i].wb, t[i].rd);
        end
      end else if (!op_mis(t[i].op, t[i].addr)) begin
        n_vec++;
        if (o_wdata !== t[i].wdata) begin
          n_bad++;
          $display("FAIL dir%0d_wdata got %h want %h", i, o_wdata, t[i].wdata);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    int wb_seen;
    valid_i = 1'b1; set_flags(2); alu_p_i = 32'h0000_0040; rs2_data_i = 32'h0; rd_idx_i = 5'd7;
    @(posedge clk); #1;
    valid_i = 1'b0; set_flags(-1); mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({ready_o, mem_req_o, wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL midop_reset_abort got ready=%b req=%b wb_valid=%b rd=%0d data=%h want ready=1 req=0 wb_valid=0 rd=0 data=0",
               ready_o, mem_req_o, wb_valid_o, wb_rd_o, wb_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    wb_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      @(negedge clk);
      if (wb_valid_o) wb_seen++;
    end
    mem_rvalid_i = 1'b0;
    n_vec++;
    if ({8'(wb_seen), ready_o} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL stale_rvalid got wb_pulses=%0d ready=%b want wb_pulses=0 ready=1", wb_seen, ready_o);
    end
    last_load = 32'd0;
  endtask

  task automatic test_random(input int n);
    int          op, gd, rvd;
    bit          noise;
    logic [31:0] addr, rs2, rdata, exp_ld;
    logic [4:0]  rd;
    logic [63:0] exp_ctl;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 7);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(op_size(op)) - 32'd1);
      rs2 = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3); noise = 1'($urandom_range(0, 1));
      do_op(op, addr, rs2, rd, rdata, gd, rvd, noise);
      exp_ctl = m_ctl(op, addr, gd, rvd);
      n_vec++;
      if (obs_ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL rnd%0d_ctl op=%0d addr=%h gd=%0d rvd=%0d got %h want %h", i, op, addr, gd, rvd, obs_ctl(), exp_ctl);
      end
      if (!op_mis(op, addr)) begin
        n_vec++;
        if ({o_addr, o_we, o_wstrb, o_unstable} !== {addr & 32'hFFFF_FFFC, !op_load(op), m_strb(op, addr), 1'b0}) begin
          n_bad++;
          $display("FAIL rnd%0d_req op=%0d got addr=%h we=%b strb=%b unstable=%b want addr=%h we=%b strb=%b unstable=0",
                   i, op, o_addr, o_we, o_wstrb, o_unstable, addr & 32'hFFFF_FFFC, !op_load(op), m_strb(op, addr));
        end
      end
      if (op_load(op) && !op_mis(op, addr)) begin
        exp_ld = m_load(op, addr, rdata);
        n_vec++;
        if ({o_wb_data, o_wb_rd} !== {exp_ld, rd}) begin
          n_bad++;
          $display("FAIL rnd%0d_wb op=%0d addr=%h rdata=%h got data=%h rd=%0d want data=%h rd=%0d",
                   i, op, addr, rdata, o_wb_data, o_wb_rd, exp_ld, rd);
        end
        last_load = exp_ld;
      end else begin
        if (!op_mis(op, addr)) begin
          n_vec++;
          if (o_wdata !== m_wdata(op, rs2)) begin
            n_bad++;
            $display("FAIL rnd%0d_wdata op=%0d rs2=%h got %h want %h", i, op, rs2, o_wdata, m_wdata(op, rs2));
          end
        end
        n_vec++;
        if (wb_data_o !== last_load) begin
          n_bad++;
          $display("FAIL rnd%0d_wb_hold got %h want %h", i, wb_data_o, last_load);
        end
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    do_op(2, 32'h0000_0010, 32'h0, 5'd4, 32'h5555_AAAA, 0, 20, 1'b0);
    n_vec++;
    if (obs_ctl() !== 64'h01_06_07_00_00_00_01_01) begin
      n_bad++;
      $display("FAIL timeout_rvalid got %h want %h", obs_ctl(), 64'h01_06_07_00_00_00_01_01);
    end
    do_op(7, 32'h0000_0020, 32'h1, 5'd0, 32'h0, 20, 0, 1'b0);
    n_vec++;
    if (obs_ctl() !== 64'h04_05_06_00_00_00_01_01) begin
      n_bad++;
      $display("FAIL timeout_gnt got %h want %h", obs_ctl(), 64'h04_05_06_00_00_00_01_01);
    end
  endtask
`endif

  initial begin
    valid_i = 1'b0; set_flags(-1); alu_p_i = '0; rs2_data_i = '0; rd_idx_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; rst = 1'b0;
    test_reset();
    test_no_flag();
    test_directed();
    test_reset_midop();
    test_random(60);
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
